// File: rtl/up_bus_if_pkg.sv
// -----------------------------------------------------------------------------
// up_bus_if_pkg
// Shared definitions for the processor bus interface: the FSM state
// encodings (2-bit) and the width of the wait-state counter.
// No ports (package).
// -----------------------------------------------------------------------------
package up_bus_if_pkg;

    typedef enum logic [1:0] {
        UP_BUS_IDLE   = 2'd0,
        UP_BUS_ACCESS = 2'd1,
        UP_BUS_DONE   = 2'd2
    } up_bus_state_t;

    // Wait counter width; holds WAIT values 0..15.
    localparam int UP_BUS_CNT_W = 4;

endpackage

// File: rtl/up_addr_latch.sv
// -----------------------------------------------------------------------------
// up_addr_latch
// Shift-in address register. Each ale beat shifts DATA_W bits of wdata in at
// the LSB end (MSB beat first); bits shifted above ADDR_W are discarded.
// inc adds one to the address, wrapping modulo 2^ADDR_W.
//
// Ports:
//   clk    in  1        rising-edge clock
//   nRst   in  1        asynchronous active-low reset (addr -> 0)
//   ale    in  1        shift wdata into the address
//   inc    in  1        increment the address (ale has priority)
//   wdata  in  DATA_W   address beat
//   addr   out ADDR_W   current address
// -----------------------------------------------------------------------------
module up_addr_latch #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              ale,
    input  logic              inc,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] shifted;

    generate
        if (ADDR_W > DATA_W) begin : g_wide
            assign shifted = {addr[ADDR_W-DATA_W-1:0], wdata};
        end else begin : g_narrow
            // A single beat covers the whole address.
            assign shifted = wdata[ADDR_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            addr <= '0;
        end else if (ale) begin
            addr <= shifted;
        end else if (inc) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/up_bus_if.sv
// -----------------------------------------------------------------------------
// up_bus_if
// Bus interface between the processor datapath/controller and a memory slave.
// Builds the address from ALE beats, runs each read/write through WAIT+1
// strobe cycles, then pulses ready for one cycle with the read word registered.
//
// Optional feature: define UP_BUS_AUTOINC_EN to increment the address on
// every DONE cycle (block transfers without re-issuing ale).
//
// Ports:
//   clk        in  1        rising-edge clock
//   nRst       in  1        asynchronous active-low reset
//   ale        in  1        shift wdata into the address register
//   re, we     in  1        read / write request (both together is illegal)
//   wdata      in  DATA_W   address beat or write data
//   rdata      out DATA_W   last completed read word
//   ready      out 1        one-cycle completion pulse
//   busy       out 1        high while an access is in progress
//   err        out 1        one-cycle pulse on an illegal request
//   mem_addr   out ADDR_W   memory address
//   mem_re     out 1        memory read strobe
//   mem_we     out 1        memory write strobe
//   mem_wdata  out DATA_W   captured write data
//   mem_rdata  in  DATA_W   memory read data
// -----------------------------------------------------------------------------
module up_bus_if
    import up_bus_if_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              ale,
    input  logic              re,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    up_bus_state_t           state;
    logic [UP_BUS_CNT_W-1:0] cnt;
    logic                    is_read;
    logic [ADDR_W-1:0]       addr;
    logic [ADDR_W-1:0]       acc_addr;
    logic                    ale_ok;
    logic                    inc;

    // ale outside IDLE is ignored so the address cannot move under a strobe.
    assign ale_ok = ale && (state == UP_BUS_IDLE);

`ifdef UP_BUS_AUTOINC_EN
    assign inc = (state == UP_BUS_DONE);
`else
    assign inc = 1'b0;
`endif

    up_addr_latch #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_addr_latch (
        .clk   (clk),
        .nRst  (nRst),
        .ale   (ale_ok),
        .inc   (inc),
        .wdata (wdata),
        .addr  (addr)
    );

    // An ale beat arriving with a request updates the address register on the
    // accepting edge, but the access must use the old address, so a snapshot
    // is taken at acceptance and presented for the whole access. In IDLE the
    // live address register is shown so a beat is visible the next cycle.
    // Both mux inputs and the select are flops.
    assign mem_addr = (state == UP_BUS_IDLE) ? addr : acc_addr;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= UP_BUS_IDLE;
            cnt       <= '0;
            is_read   <= 1'b0;
            acc_addr  <= '0;
            rdata     <= '0;
            mem_wdata <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                UP_BUS_IDLE: begin
                    if (re && we) begin
                        err <= 1'b1;
                    end else if (re || we) begin
                        is_read   <= re;
                        mem_wdata <= wdata;
                        acc_addr  <= addr;
                        cnt       <= UP_BUS_CNT_W'(WAIT);
                        mem_re    <= re;
                        mem_we    <= we;
                        busy      <= 1'b1;
                        state     <= UP_BUS_ACCESS;
                    end
                end

                UP_BUS_ACCESS: begin
                    if (re || we || ale) begin
                        err <= 1'b1;
                    end
                    if (cnt == '0) begin
                        if (is_read) begin
                            rdata <= mem_rdata;
                        end
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        ready  <= 1'b1;
                        state  <= UP_BUS_DONE;
                    end else begin
                        cnt <= cnt - UP_BUS_CNT_W'(1);
                    end
                end

                UP_BUS_DONE: begin
                    if (re || we || ale) begin
                        err <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= UP_BUS_IDLE;
                end

                default: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= UP_BUS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_bus_if.sv
// -----------------------------------------------------------------------------
// tb_up_bus_if
// Randomized scoreboard bench for up_bus_if (DATA_W=8, ADDR_W=16, WAIT=3).
// The driver pushes expected accesses and expected err pulses into queues;
// a negedge monitor compares the DUT against them every cycle. A memory
// slave array answers mem_re and absorbs mem_we; a separate shadow array
// holds the expected memory contents.
// -----------------------------------------------------------------------------
module tb_up_bus_if;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int WAIT   = 3;

    logic              clk = 1'b0;
    logic              nRst = 1'b0;
    logic              ale = 1'b0;
    logic              re = 1'b0;
    logic              we = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    up_bus_if #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .WAIT   (WAIT)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .ale       (ale),
        .re        (re),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave: data only meaningful while mem_re is high.
    logic [7:0] mem    [65536];
    logic [7:0] shadow [65536];
    assign mem_rdata = mem_re ? mem[mem_addr] : ~mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        bit         rd;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rdx;
        int          p;     // cycle index of the first strobe cycle
    } txn_t;

    txn_t q[$];
    int   errq[$];
    logic [15:0] addr_m = '0;
    logic [7:0]  rdata_m = '0;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] shift_in(input logic [15:0] a, input logic [7:0] d);
        return 16'((int'(a) * 256 + int'(d)) % 65536);
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (nRst) begin
            bit act;
            bit strobe;
            bit done;
            txn_t t;
            act = (q.size() > 0) && (cyc >= q[0].p);
            if (act) begin
                t = q[0];
                strobe = (cyc <= t.p + WAIT);
                done   = (cyc == t.p + WAIT + 1);
                chk("busy", 32'(busy), 32'(1'b1));
                chk("mem_re", 32'(mem_re), 32'(t.rd && strobe));
                chk("mem_we", 32'(mem_we), 32'(!t.rd && strobe));
                chk("mem_addr", 32'(mem_addr), 32'(t.addr));
                if (strobe && !t.rd) chk("mem_wdata", 32'(mem_wdata), 32'(t.wd));
                chk("ready", 32'(ready), 32'(done));
                if (done) begin
                    if (t.rd) rdata_m = t.rdx;
                    void'(q.pop_front());
`ifdef UP_BUS_AUTOINC_EN
                    addr_m = 16'((int'(addr_m) + 1) % 65536);
`endif
                end
            end else begin
                chk("busy", 32'(busy), 32'(1'b0));
                chk("mem_re", 32'(mem_re), 32'(1'b0));
                chk("mem_we", 32'(mem_we), 32'(1'b0));
                chk("ready", 32'(ready), 32'(1'b0));
                chk("mem_addr_idle", 32'(mem_addr), 32'(addr_m));
            end
            chk("rdata", 32'(rdata), 32'(rdata_m));
            if (errq.size() > 0 && errq[0] == cyc) begin
                chk("err", 32'(err), 32'(1'b1));
                void'(errq.pop_front());
            end else begin
                chk("err", 32'(err), 32'(1'b0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        ale = 1'b1;
        wdata = d;
        tick();
        ale = 1'b0;
        addr_m = shift_in(addr_m, d);
    endtask

    // Issue a request; optionally drive an illegal input off cycles into the
    // access (0 = first strobe cycle, WAIT+1 = DONE cycle).
    task automatic req(input bit rd, input bit wr, input bit with_ale,
                       input logic [7:0] d, input int off, input logic [2:0] kind);
        re = rd;
        we = wr;
        ale = with_ale;
        wdata = d;
        if (rd && wr) begin
            errq.push_back(cyc + 1);
        end else begin
            q.push_back('{rd: rd, addr: addr_m, wd: d, rdx: shadow[addr_m], p: cyc + 1});
            if (wr) shadow[addr_m] = d;
        end
        tick();
        re = 1'b0;
        we = 1'b0;
        ale = 1'b0;
        if (with_ale) addr_m = shift_in(addr_m, d);
        if (!(rd && wr) && off >= 0) begin
            repeat (off) tick();
            re = kind[0];
            we = kind[1];
            ale = kind[2];
            wdata = 8'($urandom);
            errq.push_back(cyc + 1);
            tick();
            re = 1'b0;
            we = 1'b0;
            ale = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || errq.size() != 0 || busy) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            failures++;
            $display("FAIL timeout cyc=%0d actual=busy required=idle", cyc);
            q.delete();
            errq.delete();
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            shadow[i] = mem[i];
        end
        mem[16'h003C] = 8'hA5;
        shadow[16'h003C] = 8'hA5;

        // Reset values.
        repeat (3) tick();
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_re", 32'(mem_re), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        nRst = 1'b1;
        tick();

        // Reset in the 2nd ACCESS cycle of a read.
        beat(8'h3C);
        req(1'b1, 1'b0, 1'b0, 8'h00, -1, 3'd0);
        tick();
        #1;
        nRst = 1'b0;
        #1;
        chk("midrst_mem_re", 32'(mem_re), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(ready), 32'h0);
        chk("midrst_rdata", 32'(rdata), 32'h0);
        q.delete();
        errq.delete();
        addr_m = '0;
        rdata_m = '0;
        repeat (2) tick();
        nRst = 1'b1;
        repeat (3) tick();

        // Single read at 0x003C -> 0xA5.
        beat(8'h3C);
        req(1'b1, 1'b0, 1'b0, 8'h00, -1, 3'd0);
        wait_idle();
        chk("single_read_rdata", 32'(rdata), 32'hA5);

        // Two-beat address, write 0x77 to 0x1234, read back.
        beat(8'h12);
        beat(8'h34);
        chk("wide_addr", 32'(mem_addr), 32'h1234);
        req(1'b0, 1'b1, 1'b0, 8'h77, -1, 3'd0);
        wait_idle();
        beat(8'h12);
        beat(8'h34);
        req(1'b1, 1'b0, 1'b0, 8'h00, -1, 3'd0);
        wait_idle();

        // Illegal requests.
        req(1'b1, 1'b1, 1'b0, 8'h55, -1, 3'd0);
        wait_idle();
        req(1'b1, 1'b0, 1'b0, 8'h00, 1, 3'b001);
        wait_idle();
        req(1'b0, 1'b1, 1'b0, 8'h99, 2, 3'b100);
        wait_idle();

        // Address 0xFFFF read twice: wraps with autoincrement, reused without.
        beat(8'hFF);
        beat(8'hFF);
        req(1'b1, 1'b0, 1'b0, 8'h00, -1, 3'd0);
        wait_idle();
        req(1'b1, 1'b0, 1'b0, 8'h00, -1, 3'd0);
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            int kind;
            int off;
            logic [7:0] d;
            kind = int'($urandom_range(0, 5));
            d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            off = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WAIT + 1)) : -1;
            case (kind)
                0: beat(d);
                1: req(1'b1, 1'b0, 1'b0, d, off, 3'($urandom_range(1, 7)));
                2: req(1'b0, 1'b1, 1'b0, d, off, 3'($urandom_range(1, 7)));
                3: req(1'b1, 1'b0, 1'b1, d, off, 3'($urandom_range(1, 7)));
                4: req(1'b0, 1'b1, 1'b1, d, off, 3'($urandom_range(1, 7)));
                default: req(1'b1, 1'b1, 1'b0, d, -1, 3'd0);
            endcase
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
